instruction_fetch: RTL

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// instruction_fetch -- single-issue instruction fetch sequencer.
//
// Runs the loop FETCH -> WAIT -> ISSUE -> UPDATE. Each pass reads one
// instruction word, holds it for decode until it is accepted, and then
// pulses IncPC or LoadPC so the external program counter advances.
// HALT (opcode F) and a memory read timeout are terminal. Only reset
// leaves those states.
//
// Ports
//   clk, reset          clock; asynchronous active-low reset
//   enable              run request, sampled in IDLE and UPDATE only
//   pc_count            current PC; becomes the fetch address
//   zero_flag           ALU zero, sampled at the issue handshake (JZ)
//   mem_rd / mem_addr   one-cycle read request / registered read address
//   mem_data/mem_ready  read data and its completion strobe
//   instr / instr_valid instruction register and its valid flag
//   instr_ready         downstream accept
//   IncPC / LoadPC      one-cycle PC control pulses; new_count = jump target
//   halted / mem_error  terminal status flags (mem_error is sticky)
module instruction_fetch #(
  parameter logic [7:0] TIMEOUT = 8'd32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [7:0]  pc_count,
  input  logic        zero_flag,
  output logic        mem_rd,
  output logic [7:0]  mem_addr,
  input  logic [15:0] mem_data,
  input  logic        mem_ready,
  output logic [15:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        IncPC,
  output logic        LoadPC,
  output logic [7:0]  new_count,
  output logic        halted,
  output logic        mem_error
);

  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT, ISSUE, UPDATE, HALTED, ERROR
  } state_t;

  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_JZ   = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t     state;
  logic [7:0] wait_cnt;
  logic [3:0] opcode;

  assign opcode = instr[15:12];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      wait_cnt    <= 8'h00;
      instr       <= 16'h0000;
      mem_addr    <= 8'h00;
      new_count   <= 8'h00;
      mem_rd      <= 1'b0;
      instr_valid <= 1'b0;
      IncPC       <= 1'b0;
      LoadPC      <= 1'b0;
      halted      <= 1'b0;
      mem_error   <= 1'b0;
    end else begin
      // Pulse outputs are high for exactly the one state they are set entering.
      mem_rd <= 1'b0;
      IncPC  <= 1'b0;
      LoadPC <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            state  <= FETCH;
            mem_rd <= 1'b1;
          end
        end
        // The PC pulse from UPDATE lands on the same edge that enters FETCH.
        // Sampling pc_count here therefore picks up the updated value.
        FETCH: begin
          mem_addr <= pc_count;
          wait_cnt <= 8'h00;
          state    <= WAIT;
        end
        // mem_ready is tested first so a completion on the last allowed
        // cycle is still captured normally.
        WAIT: begin
          if (mem_ready) begin
            instr       <= mem_data;
            wait_cnt    <= 8'h00;
            instr_valid <= 1'b1;
            state       <= ISSUE;
          end else if (wait_cnt == TIMEOUT - 8'd1) begin
            mem_error <= 1'b1;
            state     <= ERROR;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ISSUE: begin
          if (instr_valid && instr_ready) begin
            instr_valid <= 1'b0;
            state       <= UPDATE;
            case (opcode)
              OP_HALT: begin
                halted <= 1'b1;
                state  <= HALTED;
              end
              OP_JMP: begin
                LoadPC    <= 1'b1;
                new_count <= instr[7:0];
              end
              OP_JZ: begin
                if (zero_flag) begin
                  LoadPC    <= 1'b1;
                  new_count <= instr[7:0];
                end else begin
                  IncPC <= 1'b1;
                end
              end
              default: IncPC <= 1'b1;
            endcase
          end
        end
        UPDATE: begin
          if (enable) begin
            state  <= FETCH;
            mem_rd <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        HALTED, ERROR: state <= state;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
